// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared address map and status bit layout for the SPART bus block
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int ST_TBR = 0;
    localparam int ST_RDA = 1;
    localparam int ST_OVR = 2;

endpackage

// File: rtl/spart_baud_gen.sv
// rtl/spart_baud_gen.sv - 16x-oversample baud tick down-counter with divisor reload
module spart_baud_gen #(
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] RESET_DIV = 16'h0516
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             reload,
    output logic             baud_en
);

    logic [DIV_W-1:0] cnt;
    logic             reloaded;

    // Terminal-count reload is divisor-1 so the tick period equals the divisor;
    // divisors 0 and 1 collapse to a tick every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= RESET_DIV;
            reloaded <= 1'b0;
        end else begin
            reloaded <= reload;
            if (reload)
                cnt <= divisor;
            else if (cnt == '0)
                cnt <= (divisor > DIV_W'(1)) ? divisor - DIV_W'(1) : '0;
            else
                cnt <= cnt - DIV_W'(1);
        end
    end

    assign baud_en = (cnt == '0) && !reloaded;

endmodule

// File: rtl/spart_bus_baud.sv
// rtl/spart_bus_baud.sv - SPART bus register file, TX/RX handshakes and baud generator
module spart_bus_baud
    import spart_pkg::*;
#(
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] RESET_DIV = 16'h0516
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       tbr,
    output logic       rda,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       baud_en
);

    localparam logic [15:0] RESET16 = 16'(RESET_DIV);

    logic       rd, wr, rd_buf, rd_stat, wr_buf, wr_dbl, wr_dbh;
    logic       ovr;
    logic [7:0] div_lo, div_hi, rx_buf, rd_data, status;

    assign rd      = iocs && iorw;
    assign wr      = iocs && !iorw;
    assign rd_buf  = rd && (ioaddr == ADDR_BUF);
    assign rd_stat = rd && (ioaddr == ADDR_STAT);
    assign wr_buf  = wr && (ioaddr == ADDR_BUF);
    assign wr_dbl  = wr && (ioaddr == ADDR_DBL);
    assign wr_dbh  = wr && (ioaddr == ADDR_DBH);

    always_comb begin
        status         = '0;
        status[ST_TBR] = tbr;
        status[ST_RDA] = rda;
        status[ST_OVR] = ovr;
    end

    always_comb begin
        rd_data = rx_buf;
        case (ioaddr)
            ADDR_BUF:  rd_data = rx_buf;
            ADDR_STAT: rd_data = status;
            ADDR_DBL:  rd_data = div_lo;
            ADDR_DBH:  rd_data = div_hi;
            default:   rd_data = rx_buf;
        endcase
    end

    assign databus = rd ? rd_data : 8'hzz;

    // A buffer write is judged on the pre-edge tbr, so an accepted write takes
    // priority over a same-cycle tx_done that would otherwise be ignored anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbr     <= 1'b1;
            rda     <= 1'b0;
            ovr     <= 1'b0;
            tx_load <= 1'b0;
            tx_data <= '0;
            rx_buf  <= '0;
            div_lo  <= RESET16[7:0];
            div_hi  <= RESET16[15:8];
        end else begin
            tx_load <= 1'b0;
            if (wr_buf && tbr) begin
                tx_data <= databus;
                tbr     <= 1'b0;
                tx_load <= 1'b1;
            end else if (tx_done) begin
                tbr <= 1'b1;
            end

            if (wr_dbl) div_lo <= databus;
            if (wr_dbh) div_hi <= databus;

            if (rx_valid) begin
                rx_buf <= rx_data;
                rda    <= 1'b1;
            end else if (rd_buf) begin
                rda <= 1'b0;
            end

            // Overrun set wins over the clear-on-status-read.
            if (rx_valid && rda && !rd_buf)
                ovr <= 1'b1;
            else if (rd_stat)
                ovr <= 1'b0;
        end
    end

    spart_baud_gen #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .divisor (DIV_W'({wr_dbh ? databus : div_hi, div_lo})),
        .reload  (wr_dbh),
        .baud_en (baud_en)
    );

endmodule
